fx_sequencer: RTL and testbench

//  Selects which effect the 16-pattern seven-segment effect generator shows, driving its 4-bit select.

---
 rtl/fx_sequencer.sv | 156 +++++++++++++++
 tb/tb_fx_sequencer.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fx_sequencer.sv
// Picks which of the 16 seven-segment effects is shown: from switches, button steps,
// a dwell timer or an LFSR shuffle, with a blanking gap between effects.
module fx_sequencer #(
   parameter int          DEBOUNCE_CYC = 4,
   parameter int          DWELL_TICKS  = 16,
   parameter int          BLANK_TICKS  = 2,
   parameter logic [7:0]  LFSR_SEED    = 8'hA5
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_tick,
   input  logic       i_btn,
   input  logic [1:0] i_mode,
   input  logic [3:0] i_sel_man,
   output logic [3:0] o_sel,
   output logic       o_blank,
   output logic       o_change
);

   localparam int DB_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
   localparam int DW_W = (DWELL_TICKS > 1) ? $clog2(DWELL_TICKS) : 1;
   localparam int BK_W = (BLANK_TICKS > 1) ? $clog2(BLANK_TICKS) : 1;
   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYC - 1);
   localparam logic [DW_W-1:0] DW_LAST = DW_W'(DWELL_TICKS - 1);
   localparam logic [BK_W-1:0] BK_LAST = BK_W'((BLANK_TICKS > 0) ? BLANK_TICKS - 1 : 0);

   typedef enum logic {SHOW, BLANK} state_t;

   logic            btn_meta, btn_sync, btn_level, btn_level_q;
   logic [DB_W-1:0] db_cnt;
   logic            press;
   logic [7:0]      lfsr;
   logic [1:0]      mode_q;

   state_t          state, state_n;
   logic [DW_W-1:0] dwell, dwell_n, dwell_eff;
   logic [BK_W-1:0] blank_cnt, blank_cnt_n;
   logic [3:0]      pending, pending_n, sel_n, sel_inc, next_val;
   logic            blank_n, change_n, advance, mode_changed;

   // Debounced level only follows the synchronised button after DEBOUNCE_CYC disagreeing cycles
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         btn_meta    <= 1'b0;
         btn_sync    <= 1'b0;
         btn_level   <= 1'b0;
         btn_level_q <= 1'b0;
         db_cnt      <= '0;
         lfsr        <= LFSR_SEED;
         mode_q      <= 2'b00;
      end else begin
         btn_meta    <= i_btn;
         btn_sync    <= btn_meta;
         btn_level_q <= btn_level;
         if (btn_sync == btn_level) begin
            db_cnt <= '0;
         end else if (db_cnt == DB_LAST) begin
            btn_level <= btn_sync;
            db_cnt    <= '0;
         end else begin
            db_cnt <= db_cnt + DB_W'(1);
         end
         lfsr   <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
         mode_q <= i_mode;
      end
   end

   assign press        = btn_level & ~btn_level_q;
   assign mode_changed = (i_mode != mode_q);
   assign dwell_eff    = mode_changed ? '0 : dwell;
   assign sel_inc      = o_sel + 4'd1;
   assign next_val     = (i_mode == 2'b11) ? ((lfsr[3:0] == o_sel) ? sel_inc : lfsr[3:0]) : sel_inc;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state     <= SHOW;
         dwell     <= '0;
         blank_cnt <= '0;
         pending   <= 4'd0;
         o_sel     <= 4'd0;
         o_blank   <= 1'b0;
         o_change  <= 1'b0;
      end else begin
         state     <= state_n;
         dwell     <= dwell_n;
         blank_cnt <= blank_cnt_n;
         pending   <= pending_n;
         o_sel     <= sel_n;
         o_blank   <= blank_n;
         o_change  <= change_n;
      end
   end

   // Static mode tracks the switches directly; an abort out of BLANK lands on the switch value too
   always_comb begin
      state_n     = state;
      dwell_n     = dwell;
      blank_cnt_n = blank_cnt;
      pending_n   = pending;
      sel_n       = o_sel;
      blank_n     = o_blank;
      change_n    = 1'b0;
      advance     = 1'b0;
      case (state)
         SHOW: begin
            blank_n = 1'b0;
            if (i_mode == 2'b00) begin
               dwell_n  = '0;
               sel_n    = i_sel_man;
               change_n = (i_sel_man != o_sel);
            end else begin
               dwell_n = dwell_eff;
               if (i_mode == 2'b01) begin
                  advance = press;
               end else if (i_tick) begin
                  if (dwell_eff == DW_LAST) advance = 1'b1;
                  else                      dwell_n = dwell_eff + DW_W'(1);
               end
               if (advance) begin
                  dwell_n = '0;
                  if (BLANK_TICKS > 0) begin
                     state_n     = BLANK;
                     blank_n     = 1'b1;
                     blank_cnt_n = '0;
                     pending_n   = next_val;
                  end else begin
                     sel_n    = next_val;
                     change_n = 1'b1;
                  end
               end
            end
         end
         BLANK: begin
            if (i_mode == 2'b00) begin
               state_n  = SHOW;
               blank_n  = 1'b0;
               dwell_n  = '0;
               sel_n    = i_sel_man;
               change_n = (i_sel_man != o_sel);
            end else if (i_tick) begin
               if (blank_cnt == BK_LAST) begin
                  state_n  = SHOW;
                  blank_n  = 1'b0;
                  dwell_n  = '0;
                  sel_n    = pending;
                  change_n = 1'b1;
               end else begin
                  blank_cnt_n = blank_cnt + BK_W'(1);
               end
            end
         end
         default: state_n = SHOW;
      endcase
   end

endmodule

// File: tb/tb_fx_sequencer.sv
// Directed bench for fx_sequencer: auto-cycle, button step, shuffle, static, abort/reset,
// plus a second instance with no blanking gap and one-tick dwell.
module tb_fx_sequencer;

   logic       clk, rst_n, tick, btn;
   logic [1:0] mode;
   logic [3:0] sel_man;
   logic [3:0] sel, sel_f;
   logic       blank, change, blank_f, change_f;

   int checks = 0;
   int errors = 0;
   int change_total = 0;
   logic [7:0] lfsr_m;
   logic [3:0] exp_sel;

   fx_sequencer #(.DEBOUNCE_CYC(4), .DWELL_TICKS(16), .BLANK_TICKS(2), .LFSR_SEED(8'hA5)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_tick(tick), .i_btn(btn), .i_mode(mode),
      .i_sel_man(sel_man), .o_sel(sel), .o_blank(blank), .o_change(change));

   fx_sequencer #(.DEBOUNCE_CYC(4), .DWELL_TICKS(1), .BLANK_TICKS(0), .LFSR_SEED(8'hA5)) dut_fast (
      .i_clk(clk), .i_rst_n(rst_n), .i_tick(tick), .i_btn(btn), .i_mode(mode),
      .i_sel_man(sel_man), .o_sel(sel_f), .o_blank(blank_f), .o_change(change_f));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference LFSR: x^8+x^6+x^5+x^4+1, new bit shifted in at the bottom
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) lfsr_m <= 8'hA5;
      else        lfsr_m <= {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
   end

   always_ff @(posedge clk) begin
      if (change) change_total <= change_total + 1;
   end

   task automatic pulse_tick(input int period);
      repeat (period - 1) @(negedge clk);
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; tick = 1'b0; btn = 1'b0; mode = 2'b10; sel_man = 4'h0;
      repeat (3) @(negedge clk);
      checks++;
      if (sel !== 4'd0 || blank !== 1'b0 || change !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset: sel=%0h blank=%0b change=%0b, expected 0/0/0", sel, blank, change);
      end
      rst_n = 1'b1;
      exp_sel = 4'd0;
   endtask

   task automatic test_auto_cycle();
      for (int a = 0; a < 16; a++) begin
         repeat (15) pulse_tick(8);
         checks++;
         if (sel !== exp_sel || blank !== 1'b0) begin
            errors++;
            $display("[TB] FAIL auto_dwell adv%0d: sel=%0h blank=%0b, expected %0h/0", a, sel, blank, exp_sel);
         end
         pulse_tick(8);
         checks++;
         if (sel !== exp_sel || blank !== 1'b1) begin
            errors++;
            $display("[TB] FAIL auto_blank_start adv%0d: sel=%0h blank=%0b, expected %0h/1", a, sel, blank, exp_sel);
         end
         pulse_tick(8);
         checks++;
         if (blank !== 1'b1 || change !== 1'b0) begin
            errors++;
            $display("[TB] FAIL auto_blank_hold adv%0d: blank=%0b change=%0b, expected 1/0", a, blank, change);
         end
         pulse_tick(8);
         exp_sel = 4'(exp_sel + 4'd1);
         checks++;
         if (sel !== exp_sel || blank !== 1'b0 || change !== 1'b1) begin
            errors++;
            $display("[TB] FAIL auto_advance adv%0d: sel=%0h blank=%0b change=%0b, expected %0h/0/1",
                     a, sel, blank, change, exp_sel);
         end
         @(negedge clk);
         checks++;
         if (change !== 1'b0) begin
            errors++;
            $display("[TB] FAIL auto_change_pulse adv%0d: change=%0b, expected 0", a, change);
         end
      end
   endtask

   task automatic test_button_step();
      int start_changes;
      int waited;
      mode = 2'b01;
      @(negedge clk);
      start_changes = change_total;
      btn = 1'b1; @(negedge clk);
      btn = 1'b0; @(negedge clk);
      btn = 1'b1;
      repeat (10) @(negedge clk);
      waited = 0;
      while (blank !== 1'b1 && waited < 30) begin
         @(negedge clk);
         waited++;
      end
      checks++;
      if (blank !== 1'b1 || sel !== exp_sel) begin
         errors++;
         $display("[TB] FAIL btn_press_blank: blank=%0b sel=%0h, expected 1/%0h", blank, sel, exp_sel);
      end
      btn = 1'b0;
      repeat (10) @(negedge clk);
      btn = 1'b1;
      repeat (10) @(negedge clk);
      btn = 1'b0;
      repeat (10) @(negedge clk);
      checks++;
      if (blank !== 1'b1 || sel !== exp_sel) begin
         errors++;
         $display("[TB] FAIL btn_blank_hold: blank=%0b sel=%0h, expected 1/%0h", blank, sel, exp_sel);
      end
      pulse_tick(4);
      pulse_tick(4);
      exp_sel = 4'(exp_sel + 4'd1);
      checks++;
      if (sel !== exp_sel || blank !== 1'b0 || change !== 1'b1) begin
         errors++;
         $display("[TB] FAIL btn_advance: sel=%0h blank=%0b change=%0b, expected %0h/0/1",
                  sel, blank, change, exp_sel);
      end
      repeat (20) @(negedge clk);
      checks++;
      if (sel !== exp_sel || blank !== 1'b0 || (change_total - start_changes) !== 1) begin
         errors++;
         $display("[TB] FAIL btn_single_advance: sel=%0h blank=%0b changes=%0d, expected %0h/0/1",
                  sel, blank, change_total - start_changes, exp_sel);
      end
   endtask

   task automatic test_shuffle();
      logic [7:0]  snap;
      logic [3:0]  prev;
      logic [15:0] seen;
      int per;
      seen = 16'h0;
      mode = 2'b11;
      @(negedge clk);
      for (int a = 0; a < 200; a++) begin
         per = 1 + (a % 3);
         prev = exp_sel;
         repeat (15) pulse_tick(per);
         repeat (per - 1) @(negedge clk);
         snap = lfsr_m;
         tick = 1'b1;
         @(negedge clk);
         tick = 1'b0;
         exp_sel = (snap[3:0] == prev) ? 4'(prev + 4'd1) : snap[3:0];
         checks++;
         if (blank !== 1'b1 || sel !== prev) begin
            errors++;
            $display("[TB] FAIL shuffle_blank adv%0d: blank=%0b sel=%0h, expected 1/%0h", a, blank, sel, prev);
         end
         pulse_tick(per);
         pulse_tick(per);
         checks++;
         if (sel !== exp_sel || change !== 1'b1 || blank !== 1'b0) begin
            errors++;
            $display("[TB] FAIL shuffle_value adv%0d: sel=%0h change=%0b blank=%0b, expected %0h/1/0",
                     a, sel, change, blank, exp_sel);
         end
         checks++;
         if (sel === prev) begin
            errors++;
            $display("[TB] FAIL shuffle_repeat adv%0d: sel=%0h, required different from %0h", a, sel, prev);
         end
         seen[sel] = 1'b1;
      end
      checks++;
      if (seen !== 16'hFFFF) begin
         errors++;
         $display("[TB] FAIL shuffle_coverage: seen=%04h, expected ffff", seen);
      end
   endtask

   task automatic test_static();
      logic exp_chg;
      exp_chg = (exp_sel != 4'h9);
      mode = 2'b00;
      sel_man = 4'h9;
      @(negedge clk);
      checks++;
      if (sel !== 4'h9 || change !== exp_chg || blank !== 1'b0) begin
         errors++;
         $display("[TB] FAIL static_first: sel=%0h change=%0b blank=%0b, expected 9/%0b/0", sel, change, blank, exp_chg);
      end
      sel_man = 4'h9;
      repeat (3) begin
         @(negedge clk);
         checks++;
         if (sel !== 4'h9 || change !== 1'b0 || blank !== 1'b0) begin
            errors++;
            $display("[TB] FAIL static_same: sel=%0h change=%0b blank=%0b, expected 9/0/0", sel, change, blank);
         end
      end
      sel_man = 4'h3;
      @(negedge clk);
      checks++;
      if (sel !== 4'h3 || change !== 1'b1 || blank !== 1'b0) begin
         errors++;
         $display("[TB] FAIL static_change: sel=%0h change=%0b blank=%0b, expected 3/1/0", sel, change, blank);
      end
      @(negedge clk);
      checks++;
      if (sel !== 4'h3 || change !== 1'b0) begin
         errors++;
         $display("[TB] FAIL static_pulse: sel=%0h change=%0b, expected 3/0", sel, change);
      end
      exp_sel = 4'h3;
   endtask

   task automatic test_abort_and_reset();
      mode = 2'b10;
      repeat (16) pulse_tick(2);
      checks++;
      if (blank !== 1'b1 || sel !== 4'h3) begin
         errors++;
         $display("[TB] FAIL abort_enter_blank: blank=%0b sel=%0h, expected 1/3", blank, sel);
      end
      sel_man = 4'hC;
      mode = 2'b00;
      @(negedge clk);
      checks++;
      if (blank !== 1'b0 || sel !== 4'hC || change !== 1'b1) begin
         errors++;
         $display("[TB] FAIL abort_to_static: blank=%0b sel=%0h change=%0b, expected 0/c/1", blank, sel, change);
      end
      mode = 2'b10;
      @(negedge clk);
      repeat (16) pulse_tick(2);
      checks++;
      if (blank !== 1'b1 || sel !== 4'hC) begin
         errors++;
         $display("[TB] FAIL reset_enter_blank: blank=%0b sel=%0h, expected 1/c", blank, sel);
      end
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (sel !== 4'd0 || blank !== 1'b0 || change !== 1'b0) begin
         errors++;
         $display("[TB] FAIL async_reset: sel=%0h blank=%0b change=%0b, expected 0/0/0", sel, blank, change);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_no_gap();
      logic [3:0] exp_f;
      exp_f = 4'd0;
      checks++;
      if (sel_f !== 4'd0 || blank_f !== 1'b0) begin
         errors++;
         $display("[TB] FAIL nogap_start: sel=%0h blank=%0b, expected 0/0", sel_f, blank_f);
      end
      for (int k = 1; k <= 20; k++) begin
         pulse_tick(3);
         exp_f = 4'(exp_f + 4'd1);
         checks++;
         if (sel_f !== exp_f || change_f !== 1'b1 || blank_f !== 1'b0) begin
            errors++;
            $display("[TB] FAIL nogap_tick%0d: sel=%0h change=%0b blank=%0b, expected %0h/1/0",
                     k, sel_f, change_f, blank_f, exp_f);
         end
         @(negedge clk);
         checks++;
         if (change_f !== 1'b0 || blank_f !== 1'b0) begin
            errors++;
            $display("[TB] FAIL nogap_idle%0d: change=%0b blank=%0b, expected 0/0", k, change_f, blank_f);
         end
      end
   endtask

   initial begin
      test_reset();
      test_auto_cycle();
      test_button_step();
      test_shuffle();
      test_static();
      test_abort_and_reset();
      test_no_gap();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
